// File: rtl/cu_wb_arbiter.sv
// Compute-unit write-back stage.
// NUM_UNITS buffered result ports share one registered RF write port through a
// round-robin arbiter. Bus-connect writes pre-empt unit results. A per-register
// scoreboard stalls issue while a result for a referenced register is in flight.

// One-entry holding register for a single functional unit.
module cu_wb_hold #(
  parameter int DW = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          vld,
  input  logic [AW-1:0] wadd,
  input  logic [DW-1:0] dt,
  input  logic          grant,
  output logic          rdy,
  output logic          hold_v,
  output logic [AW-1:0] hold_wadd,
  output logic [DW-1:0] hold_dt
);

  // A granted entry drains this cycle, so it can take a new result at once.
  assign rdy = reset & (~hold_v | grant);

  // Capture a new result, or drop the entry once it has been granted.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hold_v    <= 1'b0;
      hold_wadd <= '0;
      hold_dt   <= '0;
    end else if (vld & rdy) begin
      hold_v    <= 1'b1;
      hold_wadd <= wadd;
      hold_dt   <= dt;
    end else if (grant) begin
      hold_v    <= 1'b0;
    end
  end

endmodule

module cu_wb_arbiter #(
  parameter int RF_DATASIZE   = 16,
  parameter int ADDRESS_WIDTH = 4,
  parameter int NUM_UNITS     = 3
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 issue_en,
  input  logic [ADDRESS_WIDTH-1:0]             issue_wadd,
  input  logic [ADDRESS_WIDTH-1:0]             issue_raddx,
  input  logic [ADDRESS_WIDTH-1:0]             issue_raddy,
  output logic                                 issue_stall,
  input  logic [NUM_UNITS-1:0]                 unit_vld,
  input  logic [NUM_UNITS*ADDRESS_WIDTH-1:0]   unit_wadd,
  input  logic [NUM_UNITS*RF_DATASIZE-1:0]     unit_dt,
  output logic [NUM_UNITS-1:0]                 unit_rdy,
  input  logic                                 bc_w_en,
  input  logic [ADDRESS_WIDTH-1:0]             bc_wadd,
  input  logic [RF_DATASIZE-1:0]               bc_dt,
  output logic                                 rf_w_en,
  output logic [ADDRESS_WIDTH-1:0]             rf_wadd,
  output logic [RF_DATASIZE-1:0]               rf_dt,
  output logic [(2**ADDRESS_WIDTH)-1:0]        sb_busy
);

  localparam int AW       = ADDRESS_WIDTH;
  localparam int DW       = RF_DATASIZE;
  localparam int SB_DEPTH = 1 << AW;
  localparam int PTR_W    = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  typedef struct packed {
    logic          en;
    logic [AW-1:0] wadd;
    logic [DW-1:0] dt;
  } wb_req_t;

  logic [NUM_UNITS-1:0]         hold_v;
  logic [NUM_UNITS-1:0][AW-1:0] hold_wadd;
  logic [NUM_UNITS-1:0][DW-1:0] hold_dt;
  logic [NUM_UNITS-1:0]         grant;
  logic                         gnt_any;
  logic [AW-1:0]                gnt_wadd;
  logic [DW-1:0]                gnt_dt;
  logic [PTR_W-1:0]             ptr, ptr_nxt;
  wb_req_t                      wb_nxt;
  logic                         hazard;
  logic [SB_DEPTH-1:0]          sb_set, sb_clr;

  // Per-unit holding registers.
  for (genvar gi = 0; gi < NUM_UNITS; gi++) begin : g_unit
    cu_wb_hold #(.DW(DW), .AW(AW)) u_hold (
      .clk       (clk),
      .reset     (reset),
      .vld       (unit_vld[gi]),
      .wadd      (unit_wadd[gi*AW +: AW]),
      .dt        (unit_dt[gi*DW +: DW]),
      .grant     (grant[gi]),
      .rdy       (unit_rdy[gi]),
      .hold_v    (hold_v[gi]),
      .hold_wadd (hold_wadd[gi]),
      .hold_dt   (hold_dt[gi])
    );
  end

  // Circular search from the pointer; a bus-connect write blocks all grants.
  always_comb begin
    int idx;
    idx      = 0;
    grant    = '0;
    gnt_any  = 1'b0;
    gnt_wadd = '0;
    gnt_dt   = '0;
    ptr_nxt  = ptr;
    if (!bc_w_en) begin
      for (int k = 0; k < NUM_UNITS; k++) begin
        idx = int'(ptr) + k;
        if (idx >= NUM_UNITS) idx = idx - NUM_UNITS;
        if (!gnt_any && hold_v[idx]) begin
          gnt_any     = 1'b1;
          grant[idx]  = 1'b1;
          gnt_wadd    = hold_wadd[idx];
          gnt_dt      = hold_dt[idx];
          ptr_nxt     = (idx == NUM_UNITS - 1) ? '0 : PTR_W'(idx + 1);
        end
      end
    end
  end

  // Round-robin pointer.
  always_ff @(posedge clk) begin
    if (!reset) ptr <= '0;
    else        ptr <= ptr_nxt;
  end

  // Select the write for the next edge: bus-connect first, then the granted unit.
  always_comb begin
    wb_nxt = '{en: 1'b0, wadd: rf_wadd, dt: rf_dt};
    if (bc_w_en)      wb_nxt = '{en: 1'b1, wadd: bc_wadd, dt: bc_dt};
    else if (gnt_any) wb_nxt = '{en: 1'b1, wadd: gnt_wadd, dt: gnt_dt};
  end

  // Registered RF write port; address and data hold when idle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rf_w_en <= 1'b0;
      rf_wadd <= '0;
      rf_dt   <= '0;
    end else begin
      rf_w_en <= wb_nxt.en;
      if (wb_nxt.en) begin
        rf_wadd <= wb_nxt.wadd;
        rf_dt   <= wb_nxt.dt;
      end
    end
  end

  // Hazard detection and scoreboard set/clear vectors.
  always_comb begin
    hazard      = sb_busy[issue_raddx] | sb_busy[issue_raddy] | sb_busy[issue_wadd];
    issue_stall = reset & issue_en & hazard;
    sb_set      = (reset & issue_en & ~hazard) ? (SB_DEPTH'(1) << issue_wadd) : '0;
    sb_clr      = gnt_any ? (SB_DEPTH'(1) << gnt_wadd) : '0;
  end

  // Scoreboard: a set in the same cycle as a clear of that register wins.
  always_ff @(posedge clk) begin
    if (!reset) sb_busy <= '0;
    else        sb_busy <= (sb_busy & ~sb_clr) | sb_set;
  end

endmodule

// File: tb/tb_cu_wb_arbiter.sv
// Directed bench for cu_wb_arbiter (default parameters: 16-bit data, 4-bit address, 3 units).
module tb_cu_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_en;
  logic [3:0]  issue_wadd, issue_raddx, issue_raddy;
  logic        issue_stall;
  logic [2:0]  unit_vld;
  logic [11:0] unit_wadd;
  logic [47:0] unit_dt;
  logic [2:0]  unit_rdy;
  logic        bc_w_en;
  logic [3:0]  bc_wadd;
  logic [15:0] bc_dt;
  logic        rf_w_en;
  logic [3:0]  rf_wadd;
  logic [15:0] rf_dt;
  logic [15:0] sb_busy;

  int errors = 0;
  int checks = 0;

  cu_wb_arbiter #(.RF_DATASIZE(16), .ADDRESS_WIDTH(4), .NUM_UNITS(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .issue_en    (issue_en),
    .issue_wadd  (issue_wadd),
    .issue_raddx (issue_raddx),
    .issue_raddy (issue_raddy),
    .issue_stall (issue_stall),
    .unit_vld    (unit_vld),
    .unit_wadd   (unit_wadd),
    .unit_dt     (unit_dt),
    .unit_rdy    (unit_rdy),
    .bc_w_en     (bc_w_en),
    .bc_wadd     (bc_wadd),
    .bc_dt       (bc_dt),
    .rf_w_en     (rf_w_en),
    .rf_wadd     (rf_wadd),
    .rf_dt       (rf_dt),
    .sb_busy     (sb_busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_unit(input int i, input logic v, input logic [3:0] a, input logic [15:0] d);
    unit_vld[i]        = v;
    unit_wadd[i*4 +: 4]  = a;
    unit_dt[i*16 +: 16]  = d;
  endtask

  task automatic idle_inputs();
    issue_en = 1'b0; issue_wadd = '0; issue_raddx = '0; issue_raddy = '0;
    unit_vld = '0; unit_wadd = '0; unit_dt = '0;
    bc_w_en = 1'b0; bc_wadd = '0; bc_dt = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    issue_en = 1'b1;
    tick(); tick();
    checks++; if (unit_rdy !== 3'b000) begin errors++; $display("FAIL rst_rdy_low got %b exp 000", unit_rdy); end
    checks++; if (issue_stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %b exp 0", issue_stall); end
    issue_en = 1'b0;
    reset = 1'b1;
    #1;
    checks++; if (unit_rdy !== 3'b111) begin errors++; $display("FAIL rst_rdy_high got %b exp 111", unit_rdy); end
    tick();
    checks++; if (sb_busy !== 16'h0000) begin errors++; $display("FAIL rst_sb got %h exp 0000", sb_busy); end
    checks++; if (rf_w_en !== 1'b0) begin errors++; $display("FAIL rst_wen got %b exp 0", rf_w_en); end
    checks++; if ({rf_wadd, rf_dt} !== 20'h0) begin errors++; $display("FAIL rst_rf got %h/%h exp 0/0", rf_wadd, rf_dt); end
  endtask

  task automatic test_single_issue();
    issue_en = 1'b1; issue_wadd = 4'd5; issue_raddx = 4'd0; issue_raddy = 4'd0;
    #1;
    checks++; if (issue_stall !== 1'b0) begin errors++; $display("FAIL si_stall got %b exp 0", issue_stall); end
    tick();
    issue_en = 1'b0;
    checks++; if (sb_busy !== 16'h0020) begin errors++; $display("FAIL si_sb_set got %h exp 0020", sb_busy); end
    set_unit(1, 1'b1, 4'd5, 16'h1234);
    tick();
    unit_vld = '0;
    checks++; if (rf_w_en !== 1'b0 || sb_busy !== 16'h0020) begin errors++; $display("FAIL si_inflight got wen=%b sb=%h exp wen=0 sb=0020", rf_w_en, sb_busy); end
    tick();
    checks++; if ({rf_w_en, rf_wadd, rf_dt} !== {1'b1, 4'd5, 16'h1234}) begin errors++; $display("FAIL si_commit got %b/%h/%h exp 1/5/1234", rf_w_en, rf_wadd, rf_dt); end
    checks++; if (sb_busy !== 16'h0000) begin errors++; $display("FAIL si_sb_clr got %h exp 0000", sb_busy); end
    tick();
    checks++; if ({rf_w_en, rf_wadd, rf_dt} !== {1'b0, 4'd5, 16'h1234}) begin errors++; $display("FAIL si_hold got %b/%h/%h exp 0/5/1234", rf_w_en, rf_wadd, rf_dt); end
  endtask

  task automatic test_round_robin();
    logic [3:0]  exp_a [7];
    logic [15:0] exp_d [7];
    exp_a = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd8, 4'd6};
    exp_d = '{16'hA001, 16'hA002, 16'hA003, 16'hB000, 16'hB001, 16'hC002, 16'hC000};
    do_reset();
    // all three contend with pointer 0
    set_unit(0, 1'b1, 4'd1, 16'hA001);
    set_unit(1, 1'b1, 4'd2, 16'hA002);
    set_unit(2, 1'b1, 4'd3, 16'hA003);
    tick();
    unit_vld = '0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if ({rf_w_en, rf_wadd, rf_dt} !== {1'b1, exp_a[k], exp_d[k]}) begin errors++; $display("FAIL rr_order%0d got %b/%h/%h exp 1/%h/%h", k, rf_w_en, rf_wadd, rf_dt, exp_a[k], exp_d[k]); end
    end
    // pointer back at 0: units 0 and 1 contend, unit 0 first
    set_unit(0, 1'b1, 4'd4, 16'hB000);
    set_unit(1, 1'b1, 4'd5, 16'hB001);
    tick();
    unit_vld = '0;
    for (int k = 3; k < 5; k++) begin
      tick();
      checks++; if ({rf_w_en, rf_wadd, rf_dt} !== {1'b1, exp_a[k], exp_d[k]}) begin errors++; $display("FAIL rr_order%0d got %b/%h/%h exp 1/%h/%h", k, rf_w_en, rf_wadd, rf_dt, exp_a[k], exp_d[k]); end
    end
    // pointer now 2: units 0 and 2 contend, unit 2 first
    set_unit(0, 1'b1, 4'd6, 16'hC000);
    set_unit(2, 1'b1, 4'd8, 16'hC002);
    tick();
    unit_vld = '0;
    for (int k = 5; k < 7; k++) begin
      tick();
      checks++; if ({rf_w_en, rf_wadd, rf_dt} !== {1'b1, exp_a[k], exp_d[k]}) begin errors++; $display("FAIL rr_order%0d got %b/%h/%h exp 1/%h/%h", k, rf_w_en, rf_wadd, rf_dt, exp_a[k], exp_d[k]); end
    end
    tick();
    checks++; if (rf_w_en !== 1'b0) begin errors++; $display("FAIL rr_idle got %b exp 0", rf_w_en); end
  endtask

  task automatic test_bus_priority();
    set_unit(0, 1'b1, 4'd9, 16'h0B0B);
    tick();
    unit_vld = '0;
    bc_w_en = 1'b1; bc_wadd = 4'd12; bc_dt = 16'hBC01;
    #1;
    checks++; if (unit_rdy[0] !== 1'b0) begin errors++; $display("FAIL bc_rdy0_a got %b exp 0", unit_rdy[0]); end
    tick();
    checks++; if ({rf_w_en, rf_wadd, rf_dt} !== {1'b1, 4'd12, 16'hBC01}) begin errors++; $display("FAIL bc_write1 got %b/%h/%h exp 1/c/bc01", rf_w_en, rf_wadd, rf_dt); end
    bc_wadd = 4'd13; bc_dt = 16'hBC02;
    #1;
    checks++; if (unit_rdy[0] !== 1'b0) begin errors++; $display("FAIL bc_rdy0_b got %b exp 0", unit_rdy[0]); end
    tick();
    checks++; if ({rf_w_en, rf_wadd, rf_dt} !== {1'b1, 4'd13, 16'hBC02}) begin errors++; $display("FAIL bc_write2 got %b/%h/%h exp 1/d/bc02", rf_w_en, rf_wadd, rf_dt); end
    bc_w_en = 1'b0;
    #1;
    checks++; if (unit_rdy[0] !== 1'b1) begin errors++; $display("FAIL bc_rdy0_grant got %b exp 1", unit_rdy[0]); end
    tick();
    checks++; if ({rf_w_en, rf_wadd, rf_dt} !== {1'b1, 4'd9, 16'h0B0B}) begin errors++; $display("FAIL bc_unit_after got %b/%h/%h exp 1/9/0b0b", rf_w_en, rf_wadd, rf_dt); end
    tick();
  endtask

  task automatic test_back_to_back();
    set_unit(0, 1'b1, 4'd3, 16'h0001);
    tick();
    set_unit(0, 1'b1, 4'd3, 16'h0002);
    #1;
    checks++; if (unit_rdy[0] !== 1'b1) begin errors++; $display("FAIL b2b_rdy got %b exp 1", unit_rdy[0]); end
    tick();
    unit_vld = '0;
    checks++; if ({rf_w_en, rf_dt} !== {1'b1, 16'h0001}) begin errors++; $display("FAIL b2b_first got %b/%h exp 1/0001", rf_w_en, rf_dt); end
    tick();
    checks++; if ({rf_w_en, rf_dt} !== {1'b1, 16'h0002}) begin errors++; $display("FAIL b2b_second got %b/%h exp 1/0002", rf_w_en, rf_dt); end
    tick();
  endtask

  task automatic test_hazard();
    issue_en = 1'b1; issue_wadd = 4'd7; issue_raddx = 4'd0; issue_raddy = 4'd0;
    tick();
    checks++; if (sb_busy !== 16'h0080) begin errors++; $display("FAIL hz_set7 got %h exp 0080", sb_busy); end
    // read-after-write on raddy
    issue_wadd = 4'd2; issue_raddx = 4'd1; issue_raddy = 4'd7;
    #1;
    checks++; if (issue_stall !== 1'b1) begin errors++; $display("FAIL hz_raw_stall got %b exp 1", issue_stall); end
    tick();
    checks++; if (sb_busy !== 16'h0080) begin errors++; $display("FAIL hz_no_set got %h exp 0080", sb_busy); end
    // write-after-write: busy destination still stalls in its clearing cycle
    issue_en = 1'b0;
    set_unit(2, 1'b1, 4'd7, 16'h7777);
    tick();
    unit_vld = '0;
    issue_en = 1'b1; issue_wadd = 4'd7; issue_raddx = 4'd0; issue_raddy = 4'd0;
    #1;
    checks++; if (issue_stall !== 1'b1) begin errors++; $display("FAIL hz_waw_stall got %b exp 1", issue_stall); end
    tick();
    issue_en = 1'b0;
    checks++; if (sb_busy !== 16'h0000 || rf_dt !== 16'h7777) begin errors++; $display("FAIL hz_clear got sb=%h dt=%h exp sb=0000 dt=7777", sb_busy, rf_dt); end
    // set and clear of register 7 in the same cycle: set wins
    set_unit(2, 1'b1, 4'd7, 16'h7778);
    tick();
    unit_vld = '0;
    issue_en = 1'b1; issue_wadd = 4'd7;
    #1;
    checks++; if (issue_stall !== 1'b0) begin errors++; $display("FAIL hz_free_stall got %b exp 0", issue_stall); end
    tick();
    issue_en = 1'b0;
    checks++; if (sb_busy !== 16'h0080 || rf_dt !== 16'h7778) begin errors++; $display("FAIL hz_set_wins got sb=%h dt=%h exp sb=0080 dt=7778", sb_busy, rf_dt); end
  endtask

  task automatic test_reset_flush();
    set_unit(0, 1'b1, 4'd10, 16'hDD00);
    set_unit(1, 1'b1, 4'd11, 16'hDD01);
    bc_w_en = 1'b1; bc_wadd = 4'd1; bc_dt = 16'h5555;
    tick();
    unit_vld = '0;
    #1;
    checks++; if (unit_rdy[1:0] !== 2'b00) begin errors++; $display("FAIL fl_full got %b exp 00", unit_rdy[1:0]); end
    reset = 1'b0;
    bc_w_en = 1'b0;
    tick();
    checks++; if ({rf_w_en, sb_busy} !== 17'h0) begin errors++; $display("FAIL fl_rst_edge got wen=%b sb=%h exp 0/0000", rf_w_en, sb_busy); end
    reset = 1'b1;
    #1;
    checks++; if (unit_rdy !== 3'b111) begin errors++; $display("FAIL fl_emptied got %b exp 111", unit_rdy); end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (rf_w_en !== 1'b0) begin errors++; $display("FAIL fl_no_write%0d got %b exp 0", k, rf_w_en); end
    end
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    test_reset();
    test_single_issue();
    test_round_robin();
    test_bus_priority();
    test_back_to_back();
    test_hazard();
    test_reset_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
